// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are handled as sign-magnitude, with the sign applied once when the product is loaded.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic               accept;
    logic               last;

    assign accept  = in_valid && (state == IDLE);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    // Negating the most negative value wraps back onto itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (signed_mode && a[WIDTH-1]) mag_a = -a;
        if (signed_mode && b[WIDTH-1]) mag_b = -b;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + CW'(1);
                    if (last) p <= neg ? -acc_sum : acc_sum;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: exhaustive 4-bit unsigned sweep plus 8-bit vector table and corner sequences.
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst;

    logic       in_valid4, in_ready4, signed_mode4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        in_valid8, in_ready8, signed_mode8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(signed_mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .p(p4), .busy(busy4)
    );

    seq_mult_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(signed_mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .p(p8), .busy(busy8)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp_p;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one operand pair to the 8-bit instance and wait (bounded) for its product.
    task automatic applyStimulus8(input logic [7:0] ai, input logic [7:0] bi, input logic sm,
                                  output logic [15:0] pr, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid8    = 1'b1;
        a8           = ai;
        b8           = bi;
        signed_mode8 = sm;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        pr = p8;
    endtask

    task automatic applyStimulus4(input logic [3:0] ai, input logic [3:0] bi,
                                  output logic [7:0] pr, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid4    = 1'b1;
        a4           = ai;
        b4           = bi;
        signed_mode4 = 1'b0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        pr = p4;
    endtask

    initial begin
        logic [15:0] pr8;
        logic [7:0]  pr4;
        int          lat;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h00, 8'hAB, 1'b0, 16'h0000};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[3]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
        vecs[4]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[5]  = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[8]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        vecs[9]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[10] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8};

        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; signed_mode4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; signed_mode8 = 1'b0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready8), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid8), 32'd0);
        checkOutput("reset busy", 32'(busy8), 32'd0);
        checkOutput("reset p", 32'(p8), 32'd0);
        checkOutput("reset p4", 32'(p4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus4(4'(i), 4'(j), pr4, lat);
                checkOutput($sformatf("w4 %0d*%0d", i, j), 32'(pr4), 32'(i * j));
                checkOutput($sformatf("w4 latency %0d*%0d", i, j), 32'(lat), 32'd4);
            end
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus8(vecs[i].a, vecs[i].b, vecs[i].sm, pr8, lat);
            checkOutput($sformatf("vec%0d p", i), 32'(pr8), 32'(vecs[i].exp_p));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
        end

        // Backpressure: hold the product for 20 cycles while a new request knocks.
        @(negedge clk);
        out_ready8 = 1'b0;
        applyStimulus8(8'h12, 8'h34, 1'b0, pr8, lat);
        checkOutput("bp p", 32'(pr8), 32'h03A8);
        @(negedge clk);
        in_valid8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp out_valid", 32'(out_valid8), 32'd1);
            checkOutput("bp p stable", 32'(p8), 32'h03A8);
            checkOutput("bp in_ready", 32'(in_ready8), 32'd0);
        end
        @(negedge clk);
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release in_ready", 32'(in_ready8), 32'd1);
        checkOutput("bp release out_valid", 32'(out_valid8), 32'd0);
        checkOutput("bp p retained", 32'(p8), 32'h03A8);
        @(posedge clk);
        #1;
        checkOutput("bp no stale accept", 32'(busy8), 32'd0);

        // Reset at the third iteration discards the operation.
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; signed_mode8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst in_ready", 32'(in_ready8), 32'd1);
        checkOutput("midrst out_valid", 32'(out_valid8), 32'd0);
        checkOutput("midrst busy", 32'(busy8), 32'd0);
        checkOutput("midrst p", 32'(p8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus8(8'd3, 8'd7, 1'b0, pr8, lat);
        checkOutput("post-reset 3*7", 32'(pr8), 32'd21);
        checkOutput("post-reset latency", 32'(lat), 32'd8);

        // Operand inputs are ignored once the multiply is under way.
        @(negedge clk);
        while (!in_ready8) @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'd12; b8 = 8'd10; signed_mode8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 60) begin
            @(negedge clk);
            a8 = 8'hFF;
            b8 = 8'hFF;
            signed_mode8 = ~signed_mode8;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("operand change p", 32'(p8), 32'd120);
        checkOutput("operand change latency", 32'(lat), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
